// File: rtl/readout_pkg.sv
// Shared types and constants for the pixel readout sequencer.
package readout_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_EXPOSE = 3'd1,
        ST_SETTLE = 3'd2,
        ST_SHIFT  = 3'd3,
        ST_DRAIN  = 3'd4
    } state_e;

    localparam int SETTLE_CYCLES = 2;

    // Index width that stays at least one bit wide for degenerate sizes.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/readout_sequencer_ser_deser.sv
// Dual-chain MSB-first deserialiser with a single output word register and valid/ready handshake.
module ser_deser
    import readout_pkg::*;
#(
    parameter  int NPIX  = 16,
    parameter  int CNT_W = 8,
    localparam int IW    = idx_w(NPIX),
    localparam int BW    = idx_w(CNT_W)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             shift_en_i,
    input  logic             ser_a_i,
    input  logic             ser_b_i,
    input  logic             ready_i,
    output logic             stall_o,
    output logic             last_o,
    output logic             valid_o,
    output logic [CNT_W-1:0] data_a_o,
    output logic [CNT_W-1:0] data_b_o,
    output logic [IW-1:0]    pix_idx_o
);

    logic [CNT_W-1:0] sh_a_q, sh_a_d, sh_b_q, sh_b_d;
    logic [CNT_W-1:0] out_a_q, out_a_d, out_b_q, out_b_d;
    logic [BW-1:0]    bit_q, bit_d;
    logic [IW-1:0]    word_q, word_d, idx_q, idx_d;
    logic             vld_q, vld_d;
    logic             word_end;

    assign word_end  = (bit_q == BW'(CNT_W - 1));
    // The completing sample must wait until the held word has been taken.
    assign stall_o   = word_end && vld_q && !ready_i;
    assign last_o    = word_end && (word_q == IW'(NPIX - 1));
    assign valid_o   = vld_q;
    assign data_a_o  = out_a_q;
    assign data_b_o  = out_b_q;
    assign pix_idx_o = idx_q;

    always_comb begin
        sh_a_d  = sh_a_q;
        sh_b_d  = sh_b_q;
        out_a_d = out_a_q;
        out_b_d = out_b_q;
        bit_d   = bit_q;
        word_d  = word_q;
        idx_d   = idx_q;
        vld_d   = vld_q;
        if (clr_i) begin
            sh_a_d = '0;
            sh_b_d = '0;
            bit_d  = '0;
            word_d = '0;
            vld_d  = 1'b0;
        end else begin
            if (vld_q && ready_i)
                vld_d = 1'b0;
            if (shift_en_i) begin
                sh_a_d = {sh_a_q[CNT_W-2:0], ser_a_i};
                sh_b_d = {sh_b_q[CNT_W-2:0], ser_b_i};
                bit_d  = word_end ? '0 : bit_q + 1'b1;
                if (word_end) begin
                    out_a_d = {sh_a_q[CNT_W-2:0], ser_a_i};
                    out_b_d = {sh_b_q[CNT_W-2:0], ser_b_i};
                    idx_d   = word_q;
                    word_d  = last_o ? '0 : word_q + 1'b1;
                    vld_d   = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sh_a_q  <= '0;
            sh_b_q  <= '0;
            out_a_q <= '0;
            out_b_q <= '0;
            bit_q   <= '0;
            word_q  <= '0;
            idx_q   <= '0;
            vld_q   <= 1'b0;
        end else begin
            sh_a_q  <= sh_a_d;
            sh_b_q  <= sh_b_d;
            out_a_q <= out_a_d;
            out_b_q <= out_b_d;
            bit_q   <= bit_d;
            word_q  <= word_d;
            idx_q   <= idx_d;
            vld_q   <= vld_d;
        end
    end

endmodule

// File: rtl/readout_sequencer.sv
// Frame sequencer: exposure gating, settle gap, serial readout of two pixel chains and word handoff.
module readout_sequencer
    import readout_pkg::*;
#(
    parameter  int NPIX  = 16,
    parameter  int CNT_W = 8,
    parameter  int EXP_W = 16,
    localparam int IW    = idx_w(NPIX)
) (
    input  logic             clk_read,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic             contMode,
    input  logic             summingCfg,
    input  logic [EXP_W-1:0] exposureLen,
    output logic             shutterA,
    output logic             shutterB,
    output logic             SummingMode,
    output logic             shiftEn,
    input  logic             SerOutA,
    input  logic             SerOutB,
    output logic             SerInA,
    output logic             SerInB,
    output logic [CNT_W-1:0] dataA,
    output logic [CNT_W-1:0] dataB,
    output logic [IW-1:0]    pixIdx,
    output logic             dataValid,
    input  logic             dataReady,
    output logic             busy,
    output logic             frameDone
);

    localparam int SW = idx_w(SETTLE_CYCLES);

    state_e           state_q, state_d;
    logic [EXP_W-1:0] exp_len_q, exp_len_d, exp_cnt_q, exp_cnt_d, exp_last;
    logic [SW-1:0]    settle_q, settle_d;
    logic             sum_q, sum_d, cont_q, cont_d;
    logic             abort_act, xfer_last, sd_stall, sd_last, sd_clr;

    assign abort_act = abort && (state_q != ST_IDLE);
    assign xfer_last = (state_q == ST_DRAIN) && dataValid && dataReady;
    // A zero exposure still opens the shutters for one cycle.
    assign exp_last  = (exp_len_q == '0) ? '0 : exp_len_q - 1'b1;
    assign sd_clr    = abort_act || (state_q == ST_EXPOSE);
    assign SerInA    = 1'b0;
    assign SerInB    = 1'b0;

    ser_deser #(
        .NPIX  (NPIX),
        .CNT_W (CNT_W)
    ) u_deser (
        .clk_i      (clk_read),
        .rst_i      (reset),
        .clr_i      (sd_clr),
        .shift_en_i (shiftEn),
        .ser_a_i    (SerOutA),
        .ser_b_i    (SerOutB),
        .ready_i    (dataReady),
        .stall_o    (sd_stall),
        .last_o     (sd_last),
        .valid_o    (dataValid),
        .data_a_o   (dataA),
        .data_b_o   (dataB),
        .pix_idx_o  (pixIdx)
    );

    always_ff @(posedge clk_read) begin
        if (reset)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (start) state_d = ST_EXPOSE;
            ST_EXPOSE: if (exp_cnt_q == exp_last) state_d = ST_SETTLE;
            ST_SETTLE: if (settle_q == SW'(SETTLE_CYCLES - 1)) state_d = ST_SHIFT;
            ST_SHIFT:  if (shiftEn && sd_last) state_d = ST_DRAIN;
            ST_DRAIN:  if (xfer_last) state_d = cont_q ? ST_EXPOSE : ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
        if (abort_act)
            state_d = ST_IDLE;
    end

    always_comb begin
        shutterA    = (state_q == ST_EXPOSE);
        shutterB    = (state_q == ST_EXPOSE);
        busy        = (state_q != ST_IDLE);
        SummingMode = sum_q && (state_q != ST_IDLE);
        shiftEn     = (state_q == ST_SHIFT) && !sd_stall;
        frameDone   = xfer_last && !abort && !reset;
    end

    always_comb begin
        exp_len_d = exp_len_q;
        sum_d     = sum_q;
        cont_d    = cont_q;
        if (state_q == ST_IDLE && start) begin
            exp_len_d = exposureLen;
            sum_d     = summingCfg;
            cont_d    = contMode;
        end
        exp_cnt_d = (state_q == ST_EXPOSE) ? exp_cnt_q + 1'b1 : '0;
        settle_d  = (state_q == ST_SETTLE) ? settle_q + 1'b1 : '0;
    end

    always_ff @(posedge clk_read) begin
        if (reset) begin
            exp_len_q <= '0;
            exp_cnt_q <= '0;
            settle_q  <= '0;
            sum_q     <= 1'b0;
            cont_q    <= 1'b0;
        end else begin
            exp_len_q <= exp_len_d;
            exp_cnt_q <= exp_cnt_d;
            settle_q  <= settle_d;
            sum_q     <= sum_d;
            cont_q    <= cont_d;
        end
    end

endmodule

// File: tb/tb_readout_sequencer.sv
// Directed bench for readout_sequencer with NPIX=4, CNT_W=8 and a behavioural model of both pixel chains.
module tb_readout_sequencer;

    logic        clk_read = 1'b0;
    logic        reset, start, abort, contMode, summingCfg, dataReady;
    logic [15:0] exposureLen;
    logic        shutterA, shutterB, SummingMode, shiftEn, SerOutA, SerOutB, SerInA, SerInB;
    logic [7:0]  dataA, dataB;
    logic [1:0]  pixIdx;
    logic        dataValid, busy, frameDone;

    logic [7:0] patA [4] = '{8'hA5, 8'h3C, 8'hFF, 8'h01};
    logic [7:0] patB [4] = '{8'h5A, 8'hC3, 8'h00, 8'h80};

    int total = 0, passed = 0;

    // Monitor state, stepped on every rising edge.
    logic        mon_clr;
    logic [15:0] sh_cnt;
    int          cyc, sh_cyc, run, max_run, fd_cnt, nw, en_first, en_last;
    logic        seen_en, sum_bad, hold_bad, prev_hold;
    logic [17:0] prev_word;
    logic [7:0]  gotA [16];
    logic [7:0]  gotB [16];
    logic [1:0]  gotI [16];

    readout_sequencer #(.NPIX(4), .CNT_W(8), .EXP_W(16)) dut (
        .clk_read(clk_read), .reset(reset), .start(start), .abort(abort),
        .contMode(contMode), .summingCfg(summingCfg), .exposureLen(exposureLen),
        .shutterA(shutterA), .shutterB(shutterB), .SummingMode(SummingMode),
        .shiftEn(shiftEn), .SerOutA(SerOutA), .SerOutB(SerOutB),
        .SerInA(SerInA), .SerInB(SerInB), .dataA(dataA), .dataB(dataB),
        .pixIdx(pixIdx), .dataValid(dataValid), .dataReady(dataReady),
        .busy(busy), .frameDone(frameDone)
    );

    always #5 clk_read = ~clk_read;

    // Chains present the next pixel bit, MSB first, as sampled bits are consumed.
    assign SerOutA = patA[sh_cnt[4:3]][3'd7 - sh_cnt[2:0]];
    assign SerOutB = patB[sh_cnt[4:3]][3'd7 - sh_cnt[2:0]];

    always @(posedge clk_read) begin
        if (mon_clr) begin
            sh_cnt <= '0; cyc <= 0; sh_cyc <= 0; run <= 0; max_run <= 0; fd_cnt <= 0; nw <= 0;
            en_first <= 0; en_last <= 0; seen_en <= 1'b0; sum_bad <= 1'b0; hold_bad <= 1'b0;
            prev_hold <= 1'b0; prev_word <= '0;
        end else begin
            cyc <= cyc + 1;
            if (shiftEn) begin
                sh_cnt  <= sh_cnt + 16'd1;
                en_last <= cyc;
                if (!seen_en) begin en_first <= cyc; seen_en <= 1'b1; end
            end
            if (shutterA) sh_cyc <= sh_cyc + 1;
            run <= shutterA ? run + 1 : 0;
            if (shutterA && run + 1 > max_run) max_run <= run + 1;
            if (frameDone) fd_cnt <= fd_cnt + 1;
            if (dataValid && dataReady) begin
                gotA[nw[3:0]] <= dataA; gotB[nw[3:0]] <= dataB; gotI[nw[3:0]] <= pixIdx;
                nw <= nw + 1;
            end
            if (busy && !SummingMode) sum_bad <= 1'b1;
            if (prev_hold && dataValid && ({dataA, dataB, pixIdx} != prev_word)) hold_bad <= 1'b1;
            prev_hold <= dataValid && !dataReady;
            prev_word <= {dataA, dataB, pixIdx};
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic mclr();
        @(negedge clk_read); mon_clr = 1'b1;
        @(negedge clk_read); mon_clr = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk_read); start = 1'b1;
        @(negedge clk_read); start = 1'b0;
    endtask

    task automatic wait_fd(input string tag, input int n, input int lim);
        int k = 0;
        while (fd_cnt < n && k < lim) begin @(negedge clk_read); k++; end
        chk(tag, 32'(fd_cnt >= n), 1);
    endtask

    task automatic check_words(input string tag);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("%s_A%0d", tag, i), gotA[i], patA[i]);
            chk($sformatf("%s_B%0d", tag, i), gotB[i], patB[i]);
            chk($sformatf("%s_I%0d", tag, i), gotI[i], i);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; start = 1'b0; abort = 1'b0; contMode = 1'b0; summingCfg = 1'b0;
        dataReady = 1'b1; exposureLen = 16'd5; mon_clr = 1'b1;
        repeat (3) @(negedge clk_read);
        chk("rst_busy", busy, 0);       chk("rst_shA", shutterA, 0);   chk("rst_shB", shutterB, 0);
        chk("rst_shift", shiftEn, 0);   chk("rst_valid", dataValid, 0); chk("rst_fd", frameDone, 0);
        chk("rst_sum", SummingMode, 0); chk("rst_dataA", dataA, 0);     chk("rst_idx", pixIdx, 0);
        chk("rst_serin", {SerInA, SerInB}, 0);
        reset = 1'b0;
        @(negedge clk_read); mon_clr = 1'b0;

        // Basic frame, consumer always ready.
        pulse_start();
        chk("t1_busy", busy, 1);
        wait_fd("t1_done", 1, 200);
        repeat (3) @(negedge clk_read);
        chk("t1_idle", busy, 0);
        chk("t1_fd", fd_cnt, 1);
        chk("t1_shut", sh_cyc, 5);
        chk("t1_shrun", max_run, 5);
        chk("t1_shifts", sh_cnt, 32);
        chk("t1_contig", en_last - en_first + 1, 32);
        chk("t1_words", nw, 4);
        check_words("t1");

        // Consumer stalls for 20 cycles after the first word.
        mclr();
        dataReady = 1'b0;
        pulse_start();
        begin
            int k = 0;
            while (!dataValid && k < 200) begin @(negedge clk_read); k++; end
        end
        chk("t2_valid", dataValid, 1);
        repeat (20) @(negedge clk_read);
        chk("t2_stall", shiftEn, 0);
        chk("t2_hold_v", dataValid, 1);
        chk("t2_hold_A", dataA, 8'hA5);
        chk("t2_hold_I", pixIdx, 0);
        chk("t2_partial", sh_cnt, 15);
        dataReady = 1'b1;
        wait_fd("t2_done", 1, 200);
        repeat (2) @(negedge clk_read);
        chk("t2_shifts", sh_cnt, 32);
        chk("t2_words", nw, 4);
        chk("t2_lastA", gotA[3], 8'h01);
        chk("t2_lastI", gotI[3], 3);
        chk("t2_stable", hold_bad, 0);

        // Abort mid-SHIFT with a word pending.
        mclr();
        dataReady = 1'b0;
        pulse_start();
        begin
            int k = 0;
            while (sh_cnt < 12 && k < 200) begin @(negedge clk_read); k++; end
        end
        chk("t3_pre_valid", dataValid, 1);
        abort = 1'b1;
        @(negedge clk_read); abort = 1'b0;
        chk("t3_idle", busy, 0);
        chk("t3_shift", shiftEn, 0);
        chk("t3_valid", dataValid, 0);
        chk("t3_shut", shutterA, 0);
        repeat (5) @(negedge clk_read);
        chk("t3_nofd", fd_cnt, 0);
        mclr();
        dataReady = 1'b1;
        // Start and abort together in IDLE: start wins.
        @(negedge clk_read); start = 1'b1; abort = 1'b1;
        @(negedge clk_read); start = 1'b0; abort = 1'b0;
        chk("t3_startwin", busy, 1);
        wait_fd("t3_done", 1, 200);
        repeat (2) @(negedge clk_read);
        chk("t3_shifts", sh_cnt, 32);
        chk("t3_words", nw, 4);
        chk("t3_A1", gotA[1], 8'h3C);

        // Continuous summing frames with zero exposure.
        mclr();
        contMode = 1'b1; summingCfg = 1'b1; exposureLen = 16'd0;
        pulse_start();
        contMode = 1'b0; summingCfg = 1'b0;
        wait_fd("t4_done", 2, 400);
        chk("t4_reexpose", shutterA, 1);
        chk("t4_busy", busy, 1);
        @(negedge clk_read);
        chk("t4_shut1", shutterA, 0);
        chk("t4_shrun", max_run, 1);
        chk("t4_sumconst", sum_bad, 0);
        chk("t4_summode", SummingMode, 1);
        chk("t4_shifts", sh_cnt, 64);
        chk("t4_words", nw, 8);
        chk("t4_A4", gotA[4], 8'hA5);
        chk("t4_I5", gotI[5], 1);
        abort = 1'b1;
        @(negedge clk_read); abort = 1'b0;
        chk("t4_abort_sum", SummingMode, 0);
        repeat (3) @(negedge clk_read);
        chk("t4_stays_idle", busy, 0);

        // Reset during EXPOSE dominates start and abort.
        summingCfg = 1'b1; exposureLen = 16'd10;
        pulse_start();
        repeat (2) @(negedge clk_read);
        chk("t5_pre_shut", shutterA, 1);
        chk("t5_pre_A", dataA, 8'h01);
        chk("t5_pre_B", dataB, 8'h80);
        reset = 1'b1; start = 1'b1; abort = 1'b1;
        @(negedge clk_read);
        chk("t5_shA", shutterA, 0);   chk("t5_shB", shutterB, 0);   chk("t5_busy", busy, 0);
        chk("t5_sum", SummingMode, 0); chk("t5_A", dataA, 0);       chk("t5_B", dataB, 0);
        chk("t5_idx", pixIdx, 0);      chk("t5_valid", dataValid, 0); chk("t5_shift", shiftEn, 0);
        chk("t5_fd", frameDone, 0);
        repeat (2) @(negedge clk_read);
        chk("t5_hold_busy", busy, 0);
        reset = 1'b0; start = 1'b0; abort = 1'b0;
        @(negedge clk_read);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
